btn_sw_input: RTL and testbench

- Memory-mapped input peripheral: the read-side counterpart to the LED and 7-seg write peripherals on the SoC bridge.
- Synchronises and debounces the 24 board switches and 5 buttons, and latches button-press events in sticky flags.
- Counts presses and returns all status to the CPU over the bridge's peripheral read port.
- Sits between the board pins and the bridge's sw/btn peripheral interface, in the single-cycle CPU clock domain.

---
 rtl/btn_sw_input_pkg.sv | 20 ++
 rtl/btn_sw_input_debounce_bit.sv | 46 ++++
 rtl/btn_sw_input.sv | 95 +++++++++
 tb/tb_btn_sw_input.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/btn_sw_input_pkg.sv
// Shared register offsets, default timing parameters and a small popcount helper
// for the switch/button input peripheral.
package btn_sw_input_pkg;

  localparam logic [11:0] OFF_SW   = 12'h000;
  localparam logic [11:0] OFF_BTN  = 12'h004;
  localparam logic [11:0] OFF_FLAG = 12'h008;
  localparam logic [11:0] OFF_PCNT = 12'h00C;

  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_STABLE_TICKS = 4;

  function automatic logic [2:0] popcount5(input logic [4:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 5; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/btn_sw_input_debounce_bit.sv
// Single-bit debouncer: a new level is accepted only after STABLE_TICKS
// consecutive sample ticks that all differ from the current debounced level.
module debounce_bit
  import btn_sw_input_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din_sync,
  output logic dout
);

  logic [3:0] cnt_q, cnt_d;
  logic       dout_q, dout_d;

  // Any sample matching the held level restarts qualification from zero.
  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (tick) begin
      if (din_sync == dout_q) begin
        cnt_d = '0;
      end else if (cnt_q == 4'(STABLE_TICKS - 1)) begin
        dout_d = din_sync;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/btn_sw_input.sv
// Memory-mapped switch/button input peripheral: synchronise, debounce, latch
// sticky press flags, count presses and expose everything on the bridge read port.
module btn_sw_input
  import btn_sw_input_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int PCNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] addr,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [23:0] sw,
  input  logic [4:0]  button,
  output logic        press_irq
);

  localparam int NB = 29;
  localparam int PW = $clog2(TICK_DIV);

  localparam logic [9:0] W_SW   = OFF_SW[11:2];
  localparam logic [9:0] W_BTN  = OFF_BTN[11:2];
  localparam logic [9:0] W_FLAG = OFF_FLAG[11:2];
  localparam logic [9:0] W_PCNT = OFF_PCNT[11:2];

  logic [NB-1:0]     sync1_q, sync2_q, deb;
  logic [PW-1:0]     presc_q, presc_d;
  logic              tick;
  logic [4:0]        btn_prev_q, press_evt;
  logic [4:0]        flags_q, flags_d, flag_clr;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [9:0]        word;
  logic              pcnt_clr;
  logic              unused_bits;

  assign unused_bits = ^{addr[1:0], wdata[31:5]};
  assign word        = addr[11:2];

  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  for (genvar g = 0; g < NB; g++) begin : g_deb
    debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_deb (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .din_sync (sync2_q[g]),
      .dout     (deb[g])
    );
  end

  assign press_evt = deb[28:24] & ~btn_prev_q;

  // Set has priority over a simultaneous write-1-to-clear.
  assign flag_clr = (we[0] && word == W_FLAG) ? wdata[4:0] : 5'b0;
  assign flags_d  = (flags_q & ~flag_clr) | press_evt;

  assign pcnt_clr = (|we) && (word == W_PCNT);
  assign pcnt_d   = (pcnt_clr ? '0 : pcnt_q) + PCNT_W'(popcount5(press_evt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      presc_q    <= '0;
      btn_prev_q <= '0;
      flags_q    <= '0;
      pcnt_q     <= '0;
    end else begin
      sync1_q    <= {button, sw};
      sync2_q    <= sync1_q;
      presc_q    <= presc_d;
      btn_prev_q <= deb[28:24];
      flags_q    <= flags_d;
      pcnt_q     <= pcnt_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (word)
      W_SW:    rdata = {8'b0, deb[23:0]};
      W_BTN:   rdata = {27'b0, deb[28:24]};
      W_FLAG:  rdata = {27'b0, flags_q};
      W_PCNT:  rdata = 32'(pcnt_q);
      default: rdata = '0;
    endcase
  end

  assign press_irq = |flags_q;

endmodule

// File: tb/tb_btn_sw_input.sv
// Directed self-checking bench for btn_sw_input with a fast tick (TICK_DIV=4,
// STABLE_TICKS=3) and a 4-bit press counter so the wrap is reachable quickly.
module tb_btn_sw_input;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] addr;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [23:0] sw;
  logic [4:0]  button;
  logic        press_irq;

  int n_chk  = 0;
  int n_fail = 0;

  btn_sw_input #(.TICK_DIV(4), .STABLE_TICKS(3), .PCNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .we        (we),
    .wdata     (wdata),
    .rdata     (rdata),
    .sw        (sw),
    .button    (button),
    .press_irq (press_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] m);
    addr  = a;
    wdata = d;
    we    = m;
    step();
    we    = '0;
    wdata = '0;
  endtask

  // Poll a register once per cycle until it matches or the budget runs out.
  task automatic wait_rd(input string tag, input logic [11:0] a, input logic [31:0] exp,
                         input int budget);
    logic [31:0] d;
    int n;
    n = 0;
    rd(a, d);
    while (d !== exp && n < budget) begin
      step();
      rd(a, d);
      n++;
    end
    chk(tag, d, exp);
  endtask

  task automatic press_release(input logic [4:0] m);
    button = m;
    wait_rd("btn_on", 12'h004, {27'b0, m}, 30);
    button = '0;
    wait_rd("btn_off", 12'h004, 32'h0, 30);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    rst    = 1'b1;
    addr   = '0;
    we     = '0;
    wdata  = '0;
    sw     = 24'hFF_FFFF;
    button = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    wait_rd("sw_init", 12'h000, 32'h00FF_FFFF, 30);

    // Clean press on button 2
    button = 5'b00100;
    wait_rd("btn_clean", 12'h004, 32'h4, 30);
    step();
    rd(12'h008, d); chk("flag_clean", d, 32'h4);
    rd(12'h00C, d); chk("pcnt_clean", d, 32'h1);
    chk("irq_clean", {31'b0, press_irq}, 32'h1);
    button = '0;
    wait_rd("btn_release", 12'h004, 32'h0, 30);
    rd(12'h00C, d); chk("pcnt_release", d, 32'h1);

    // Asynchronous reset asserted mid-cycle
    @(posedge clk);
    #2 rst = 1'b1;
    rd(12'h000, d); chk("rst_sw", d, 32'h0);
    rd(12'h004, d); chk("rst_btn", d, 32'h0);
    rd(12'h008, d); chk("rst_flag", d, 32'h0);
    rd(12'h00C, d); chk("rst_pcnt", d, 32'h0);
    chk("rst_irq", {31'b0, press_irq}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_rd("sw_requal", 12'h000, 32'h00FF_FFFF, 30);
    rd(12'h008, d); chk("flag_after_rst", d, 32'h0);

    // Glitch: 8 clk high covers only two ticks, one short of acceptance
    button = 5'b00001;
    repeat (8) step();
    button = '0;
    repeat (20) step();
    rd(12'h004, d); chk("glitch_btn", d, 32'h0);
    rd(12'h008, d); chk("glitch_flag", d, 32'h0);
    rd(12'h00C, d); chk("glitch_pcnt", d, 32'h0);

    // Buttons 0 and 2 together, then write-1-to-clear
    press_release(5'b00101);
    rd(12'h008, d); chk("flags_5", d, 32'h5);
    rd(12'h00C, d); chk("pcnt_2", d, 32'h2);
    wr(12'h008, 32'h1, 4'h1);
    rd(12'h008, d); chk("w1c_bit0", d, 32'h4);
    wr(12'h008, 32'h4, 4'h1);
    rd(12'h008, d); chk("w1c_bit2", d, 32'h0);
    chk("irq_cleared", {31'b0, press_irq}, 32'h0);

    // Clear of bit 2 lands in the same cycle as its press event
    button = 5'b00100;
    begin
      int n;
      n = 0;
      rd(12'h004, d);
      while (d[2] !== 1'b1 && n < 30) begin
        step();
        rd(12'h004, d);
        n++;
      end
      chk("setwin_btn", d, 32'h4);
    end
    addr  = 12'h008;
    wdata = 32'h4;
    we    = 4'h1;
    step();
    we    = '0;
    wdata = '0;
    rd(12'h008, d); chk("set_wins", d, 32'h4);
    button = '0;
    wait_rd("setwin_release", 12'h004, 32'h0, 30);
    rd(12'h00C, d); chk("pcnt_3", d, 32'h3);

    // Counter: +2, full clear, wrap of the 4-bit counter
    press_release(5'b00011);
    rd(12'h00C, d); chk("pcnt_plus2", d, 32'h5);
    wr(12'h00C, 32'h0, 4'hF);
    rd(12'h00C, d); chk("pcnt_clear", d, 32'h0);
    repeat (3) press_release(5'b11111);
    rd(12'h00C, d); chk("pcnt_max", d, 32'hF);
    press_release(5'b00001);
    rd(12'h00C, d); chk("pcnt_wrap", d, 32'h0);
    press_release(5'b00010);
    rd(12'h00C, d); chk("pcnt_one", d, 32'h1);
    wr(12'h00C, 32'hFFFF, 4'h2);
    rd(12'h00C, d); chk("pcnt_clear_b1", d, 32'h0);

    // Address decode
    rd(12'h010, d); chk("rd_0x010", d, 32'h0);
    rd(12'hFFC, d); chk("rd_0xFFC", d, 32'h0);
    wr(12'h000, 32'h0, 4'hF);
    rd(12'h000, d); chk("wr_sw_ignored", d, 32'h00FF_FFFF);
    wr(12'h004, 32'h1F, 4'hF);
    rd(12'h004, d); chk("wr_btn_ignored", d, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
